// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parameterised synchronous FIFO family.
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake/status bundle between a FIFO and its producer/consumer.
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);

    logic                    flush;
    logic                    push;
    logic [WIDTH-1:0]        data_in;
    logic                    pop;
    logic                    clr_err;
    logic [WIDTH-1:0]        data_out;
    logic [calc_aw(DEPTH):0] count;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output flush, push, data_in, pop, clr_err,
        input  data_out, count, full, empty, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  flush, push, data_in, pop, clr_err,
        output data_out, count, full, empty, almost_full, almost_empty,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_occ_counter.sv
// Up/down occupancy counter with flush; inc/dec arrive already qualified.
module fifo_occ_counter
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    inc,
    input  logic                    dec,
    output logic [calc_aw(DEPTH):0] count,
    output logic                    full,
    output logic                    empty
);

    localparam int CW = calc_aw(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CW'(1);
        end else if (dec && !inc) begin
            count <= count - CW'(1);
        end
    end

    assign full  = (count == FULL_LVL);
    assign empty = (count == '0);

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with watermarks, flush and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input  logic               clk,
    input  logic               reset,
    param_sync_fifo_if.slave   bus
);

    localparam int AW = calc_aw(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_LVL = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LVL = CW'(AE_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;
    logic             do_push;
    logic             do_pop;
    fifo_err_t        err;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign pop_ok  = bus.pop && !empty;
    assign push_ok = bus.push && (!full || pop_ok);
    assign do_push = push_ok && !bus.flush;
    assign do_pop  = pop_ok && !bus.flush;

    fifo_occ_counter #(
        .DEPTH (DEPTH)
    ) u_occ (
        .clk   (clk),
        .reset (reset),
        .flush (bus.flush),
        .inc   (do_push),
        .dec   (do_pop),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in_w();
    end

    function automatic logic [WIDTH-1:0] data_in_w();
        return bus.data_in;
    endfunction

    // Set has priority over clr_err so an error in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= '0;
        end else if (!bus.flush) begin
            if (bus.clr_err)            err           <= '0;
            if (bus.push && !push_ok)   err.overflow  <= 1'b1;
            if (bus.pop && !pop_ok)     err.underflow <= 1'b1;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out = empty ? '0 : mem[rd_ptr];
`else
    logic [WIDTH-1:0] rd_data_p1;

    // Read stage: head word is captured on an accepted pop and held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_p1 <= '0;
        end else if (do_pop) begin
            rd_data_p1 <= mem[rd_ptr];
        end
    end

    assign bus.data_out = rd_data_p1;
`endif

    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AF_LVL);
    assign bus.almost_empty = (count <= AE_LVL);
    assign bus.overflow     = err.overflow;
    assign bus.underflow    = err.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed table-driven bench for param_sync_fifo (WIDTH=8, DEPTH=4, margins 1).
module tb_param_sync_fifo;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    param_sync_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    param_sync_fifo #(
        .WIDTH     (8),
        .DEPTH     (4),
        .AF_MARGIN (1),
        .AE_MARGIN (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       push, pop, flush, clr;
        logic [7:0] din;
        logic [7:0] dout;
        logic [2:0] cnt;
        logic       f, e, af, ae, ov, un;
    } vec_t;

    vec_t vt[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic p, q, fl, cl, input logic [7:0] din, dout,
                       input logic [2:0] cnt, input logic f, e, af, ae, ov, un);
        vec_t v;
        v.push = p; v.pop = q; v.flush = fl; v.clr = cl; v.din = din;
        v.dout = dout; v.cnt = cnt; v.f = f; v.e = e; v.af = af; v.ae = ae;
        v.ov = ov; v.un = un;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_status(input int idx, input logic [2:0] cnt,
                              input logic f, e, af, ae, ov, un);
        chk("count", idx, 32'(bus.count), 32'(cnt));
        chk("full", idx, 32'(bus.full), 32'(f));
        chk("empty", idx, 32'(bus.empty), 32'(e));
        chk("almost_full", idx, 32'(bus.almost_full), 32'(af));
        chk("almost_empty", idx, 32'(bus.almost_empty), 32'(ae));
        chk("overflow", idx, 32'(bus.overflow), 32'(ov));
        chk("underflow", idx, 32'(bus.underflow), 32'(un));
    endtask

    task automatic drive(input logic p, q, fl, cl, input logic [7:0] din);
        bus.push = p; bus.pop = q; bus.flush = fl; bus.clr_err = cl; bus.data_in = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 8'h00);

        //  push pop fl clr din    dout   cnt f e af ae ov un
        add(1, 0, 0, 0, 8'h11, 8'h00, 3'd1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 8'h22, 8'h00, 3'd2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 8'h33, 8'h00, 3'd3, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 8'h44, 8'h00, 3'd4, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 8'h55, 8'h00, 3'd4, 1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 8'h00, 8'h11, 3'd3, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 8'h00, 8'h22, 3'd2, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 8'h00, 8'h33, 3'd1, 0, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 8'h00, 8'h44, 3'd0, 0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 0, 8'h00, 8'h44, 3'd0, 0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 1, 8'h00, 8'h44, 3'd0, 0, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 8'h11, 8'h44, 3'd1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 8'h22, 8'h44, 3'd2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 8'h33, 8'h44, 3'd3, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 8'h44, 8'h44, 3'd4, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 0, 8'h55, 8'h11, 3'd4, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 8'h00, 8'h22, 3'd3, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 8'h00, 8'h33, 3'd2, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 8'h00, 8'h44, 3'd1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 8'h00, 8'h55, 3'd0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 0, 8'hA5, 8'h55, 3'd1, 0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'hA5, 3'd0, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 8'h00, 8'hA5, 3'd0, 0, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 8'h01, 8'hA5, 3'd1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 8'h02, 8'hA5, 3'd2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 8'h03, 8'hA5, 3'd3, 0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 8'h04, 8'hA5, 3'd0, 0, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 8'h66, 8'hA5, 3'd1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 8'h00, 8'h66, 3'd0, 0, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 8'h77, 8'h66, 3'd1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 8'h88, 8'h66, 3'd2, 0, 0, 0, 0, 0, 0);

        #1 reset = 1'b0;
        tick();
        tick();
        chk("reset_dout", 0, 32'(bus.data_out), 32'h0);
        chk_status(0, 3'd0, 0, 1, 0, 1, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].push, vt[i].pop, vt[i].flush, vt[i].clr, vt[i].din);
            tick();
`ifndef FIFO_FWFT_EN
            chk("data_out", i + 1, 32'(bus.data_out), 32'(vt[i].dout));
`endif
            chk_status(i + 1, vt[i].cnt, vt[i].f, vt[i].e, vt[i].af, vt[i].ae,
                       vt[i].ov, vt[i].un);
        end
        drive(0, 0, 0, 0, 8'h00);

        // Asynchronous reset between edges with two words held.
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async_dout", 100, 32'(bus.data_out), 32'h0);
        chk_status(100, 3'd0, 0, 1, 0, 1, 0, 0);
        tick();
        reset = 1'b1;

        drive(1, 0, 0, 0, 8'h99);
        tick();
        chk("rst_push_count", 101, 32'(bus.count), 32'd1);
`ifdef FIFO_FWFT_EN
        chk("fwft_head", 101, 32'(bus.data_out), 32'h99);
`endif
        drive(0, 1, 0, 0, 8'h00);
        tick();
`ifdef FIFO_FWFT_EN
        chk("fwft_empty_dout", 102, 32'(bus.data_out), 32'h0);
`else
        chk("rst_pop_dout", 102, 32'(bus.data_out), 32'h99);
`endif
        drive(1, 0, 0, 0, 8'h7E);
        tick();
        drive(0, 0, 0, 0, 8'h00);
`ifdef FIFO_FWFT_EN
        chk("fwft_fall", 103, 32'(bus.data_out), 32'h7E);
`else
        chk("hold_dout", 103, 32'(bus.data_out), 32'h99);
`endif
        tick();
`ifdef FIFO_FWFT_EN
        chk("fwft_hold", 104, 32'(bus.data_out), 32'h7E);
`else
        chk("hold_dout2", 104, 32'(bus.data_out), 32'h99);
`endif
        chk("last_count", 104, 32'(bus.count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
